// File: rtl/analog_axis_pkg.sv
// analog_axis_pkg: shared types and ADC conversion helpers for the analog joystick mux
package analog_axis_pkg;
  typedef enum logic {JOY, MOUSE} axis_mode_t;
  localparam logic [11:0] ADC_CENTER = 12'h7F7;
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        fire_n;
  } adc_port_t;
  localparam adc_port_t PORT_RESET = '{x: ADC_CENTER, y: ADC_CENTER, fire_n: 1'b1};
  // Offset-binary, inverted axis, low nibble replicated to span the full 12-bit range
  function automatic logic [11:0] to_adc12(input logic signed [7:0] v);
    logic [7:0] u;
    u = 8'hFF - {~v[7], v[6:0]};
    return {u, u[7:4]};
  endfunction
  function automatic logic signed [8:0] sat8(input logic signed [9:0] v);
    return v > 10'sd127 ? 9'sd127 : v < -10'sd128 ? -9'sd128 : v[8:0];
  endfunction
endpackage

// File: rtl/analog_axis_mux_if.sv
// analog_axis_mux_if: joystick/mouse inputs from hps_io and ADC-style port outputs to the core
interface analog_axis_mux_if;
  logic [24:0] ps2_mouse;
  logic        mouse_en;
  logic        swap;
  logic        recenter;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic [7:0]  joy1_x;
  logic [7:0]  joy1_y;
  logic [7:0]  joy2_x;
  logic [7:0]  joy2_y;
  logic [11:0] j1_x;
  logic [11:0] j1_y;
  logic        j1_fire_n;
  logic [11:0] j2_x;
  logic [11:0] j2_y;
  logic        j2_fire_n;
  logic        mouse_active;
  modport master (
    output ps2_mouse, mouse_en, swap, recenter, joy1, joy2, joy1_x, joy1_y, joy2_x, joy2_y,
    input  j1_x, j1_y, j1_fire_n, j2_x, j2_y, j2_fire_n, mouse_active
  );
  modport slave (
    input  ps2_mouse, mouse_en, swap, recenter, joy1, joy2, joy1_x, joy1_y, joy2_x, joy2_y,
    output j1_x, j1_y, j1_fire_n, j2_x, j2_y, j2_fire_n, mouse_active
  );
endinterface

// File: rtl/mouse_axis_accum.sv
// mouse_axis_accum: integrates one mouse axis delta with halving, per-packet clamp and 8-bit saturation
module mouse_axis_accum
  import analog_axis_pkg::*;
#(
  parameter int DELTA_MAX = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sign_i,
  input  logic [7:0]        mag_i,
  input  logic              stroke_i,
  input  logic              clear_i,
  input  logic              negate_i,
  output logic signed [8:0] acc_o
);
  localparam logic signed [9:0] LIM = 10'(DELTA_MAX);
  logic signed [8:0] acc_q, acc_d, d9;
  logic signed [9:0] dw, dc, sum;
  always_comb begin
    d9 = {sign_i, mag_i};
    dw = 10'(d9 >>> 1);
    dc = dw > LIM ? LIM : dw < -LIM ? -LIM : dw;
    sum = negate_i ? 10'(acc_q) - dc : 10'(acc_q) + dc;
    acc_d = clear_i ? '0 : stroke_i ? sat8(sum) : acc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/analog_axis_mux.sv
// analog_axis_mux: selects joystick or integrated PS/2 mouse for port A, swaps ports, converts to ADC codes
module analog_axis_mux
  import analog_axis_pkg::*;
#(
  parameter int DELTA_MAX = 10
) (
  input logic               clk_sys,
  input logic               reset,
  analog_axis_mux_if.slave  bus
);
  axis_mode_t        mode_q, mode_d;
  logic              old_stb_q, stroke, leave, a_fire;
  logic signed [8:0] ax, ay;
  logic [7:0]        a_x, a_y;
  adc_port_t         pa, pb, p1_d, p2_d, p1_q, p2_q;
  logic              mouse_active_q;
  logic              unused;
  assign unused = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2], bus.joy2[15:5], bus.joy2[3:0], ax[8], ay[8]};
  assign stroke = (old_stb_q != bus.ps2_mouse[24]) & bus.mouse_en;
  // Any digital joystick activity, a core reset or disabling the mouse hands port A back
  assign leave = |bus.joy1 | bus.recenter | ~bus.mouse_en;
  mouse_axis_accum #(.DELTA_MAX(DELTA_MAX)) u_x (
    .clk(clk_sys), .rst(reset), .sign_i(bus.ps2_mouse[4]), .mag_i(bus.ps2_mouse[15:8]),
    .stroke_i(stroke & ~leave), .clear_i(leave), .negate_i(1'b0), .acc_o(ax)
  );
  // Mouse Y grows upward while the ADC Y axis grows downward
  mouse_axis_accum #(.DELTA_MAX(DELTA_MAX)) u_y (
    .clk(clk_sys), .rst(reset), .sign_i(bus.ps2_mouse[5]), .mag_i(bus.ps2_mouse[23:16]),
    .stroke_i(stroke & ~leave), .clear_i(leave), .negate_i(1'b1), .acc_o(ay)
  );
  always_comb begin
    mode_d = leave ? JOY : stroke ? MOUSE : mode_q;
    a_x = mode_q == MOUSE ? ax[7:0] : bus.joy1_x;
    a_y = mode_q == MOUSE ? ay[7:0] : bus.joy1_y;
    a_fire = mode_q == MOUSE ? |bus.ps2_mouse[1:0] : bus.joy1[4];
    pa = '{x: to_adc12(a_x), y: to_adc12(a_y), fire_n: ~a_fire};
    pb = '{x: to_adc12(bus.joy2_x), y: to_adc12(bus.joy2_y), fire_n: ~bus.joy2[4]};
    p1_d = bus.swap ? pb : pa;
    p2_d = bus.swap ? pa : pb;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      mode_q         <= JOY;
      old_stb_q      <= 1'b0;
      p1_q           <= PORT_RESET;
      p2_q           <= PORT_RESET;
      mouse_active_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      old_stb_q      <= bus.ps2_mouse[24];
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      mouse_active_q <= mode_q == MOUSE;
    end
  assign bus.j1_x         = p1_q.x;
  assign bus.j1_y         = p1_q.y;
  assign bus.j1_fire_n    = p1_q.fire_n;
  assign bus.j2_x         = p2_q.x;
  assign bus.j2_y         = p2_q.y;
  assign bus.j2_fire_n    = p2_q.fire_n;
  assign bus.mouse_active = mouse_active_q;
endmodule

// File: tb/tb_analog_axis_mux.sv
// tb_analog_axis_mux: directed plan plus randomized stimulus against an integer reference model
module tb_analog_axis_mux;
  localparam int DM = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   stb = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   m_mouse, m_old;
  int   m_ax, m_ay;
  analog_axis_mux_if bus();
  analog_axis_mux #(.DELTA_MAX(DM)) dut (.clk_sys(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int adc(input int v);
    int u;
    u = 127 - v;
    return u * 16 + u / 16;
  endfunction
  function automatic int delta(input bit s, input logic [7:0] b);
    int d9, d;
    d9 = s ? int'(b) - 256 : int'(b);
    d = d9 >= 0 ? d9 / 2 : -((1 - d9) / 2);
    return d > DM ? DM : d < -DM ? -DM : d;
  endfunction
  function automatic int sat(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction
  task automatic mouse(input bit sx, input logic [7:0] xb, input bit sy, input logic [7:0] yb,
                       input logic [1:0] btn, input bit tog);
    stb ^= tog;
    bus.ps2_mouse = {stb, yb, xb, 2'b00, sy, sx, 2'b00, btn};
  endtask
  task automatic step();
    int ax_a, ay_a, bx, by, e1x, e1y, e2x, e2y;
    bit fa, fb, e1f, e2f, ea, stroke, leave;
    stroke = (m_old != bus.ps2_mouse[24]) && bus.mouse_en;
    leave = (bus.joy1 != 0) || bus.recenter || !bus.mouse_en;
    ax_a = m_mouse ? m_ax : int'($signed(bus.joy1_x));
    ay_a = m_mouse ? m_ay : int'($signed(bus.joy1_y));
    fa = m_mouse ? (bus.ps2_mouse[1:0] != 0) : bus.joy1[4];
    bx = int'($signed(bus.joy2_x));
    by = int'($signed(bus.joy2_y));
    fb = bus.joy2[4];
    e1x = adc(bus.swap ? bx : ax_a);
    e1y = adc(bus.swap ? by : ay_a);
    e2x = adc(bus.swap ? ax_a : bx);
    e2y = adc(bus.swap ? ay_a : by);
    e1f = bus.swap ? fb : fa;
    e2f = bus.swap ? fa : fb;
    ea = m_mouse;
    if (leave) begin
      m_mouse = 0; m_ax = 0; m_ay = 0;
    end else if (stroke) begin
      m_mouse = 1;
      m_ax = sat(m_ax + delta(bus.ps2_mouse[4], bus.ps2_mouse[15:8]));
      m_ay = sat(m_ay - delta(bus.ps2_mouse[5], bus.ps2_mouse[23:16]));
    end
    m_old = bus.ps2_mouse[24];
    @(posedge clk); #1;
    check("j1_x", bus.j1_x, e1x);
    check("j1_y", bus.j1_y, e1y);
    check("j1_fire_n", bus.j1_fire_n, !e1f);
    check("j2_x", bus.j2_x, e2x);
    check("j2_y", bus.j2_y, e2y);
    check("j2_fire_n", bus.j2_fire_n, !e2f);
    check("mouse_active", bus.mouse_active, ea);
  endtask
  task automatic model_reset();
    m_mouse = 0; m_ax = 0; m_ay = 0; m_old = 0;
  endtask
  initial begin
    bus.ps2_mouse = '0; bus.mouse_en = 0; bus.swap = 0; bus.recenter = 0;
    bus.joy1 = '0; bus.joy2 = '0;
    bus.joy1_x = '0; bus.joy1_y = '0; bus.joy2_x = '0; bus.joy2_y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_j1_x", bus.j1_x, 12'h7F7);
    check("rst_j2_y", bus.j2_y, 12'h7F7);
    check("rst_j1_fire_n", bus.j1_fire_n, 1'b1);
    check("rst_mouse_active", bus.mouse_active, 1'b0);
    @(negedge clk) rst = 0;
    step();
    bus.mouse_en = 1;
    mouse(0, 8'h1E, 0, 8'h00, 2'b00, 1); step();
    mouse(0, 8'h1E, 0, 8'h00, 2'b00, 0); step();
    check("plan_x10", bus.j1_x, 12'h757);
    check("plan_y0", bus.j1_y, 12'h7F7);
    check("plan_active", bus.mouse_active, 1'b1);
    for (int i = 0; i < 13; i++) begin
      mouse(0, 8'h7F, 0, 8'h00, 2'b00, 1); step();
    end
    mouse(0, 8'h7F, 0, 8'h00, 2'b00, 0); step();
    check("plan_xsat", bus.j1_x, 12'h000);
    mouse(1, 8'hE0, 0, 8'h00, 2'b00, 1); step();
    mouse(1, 8'hE0, 0, 8'h00, 2'b00, 0); step();
    check("plan_x117", bus.j1_x, 12'h0A0);
    mouse(0, 8'h00, 0, 8'h08, 2'b00, 1); step();
    mouse(0, 8'h00, 0, 8'h08, 2'b00, 0); step();
    check("plan_y_neg4", bus.j1_y, 12'h838);
    bus.swap = 1;
    mouse(0, 8'h00, 0, 8'h00, 2'b01, 0); step();
    check("swap_j2_x", bus.j2_x, 12'h0A0);
    check("swap_j2_fire", bus.j2_fire_n, 1'b0);
    check("swap_j1_x", bus.j1_x, 12'h7F7);
    bus.joy1 = 16'h0010;
    step(); step();
    check("exit_j2_x", bus.j2_x, 12'h7F7);
    check("exit_j2_fire", bus.j2_fire_n, 1'b0);
    check("exit_active", bus.mouse_active, 1'b0);
    bus.joy1 = '0; bus.swap = 0;
    bus.recenter = 1;
    mouse(0, 8'h1E, 0, 8'h00, 2'b00, 1); step();
    bus.recenter = 0;
    step();
    check("recenter_active", bus.mouse_active, 1'b0);
    check("recenter_x", bus.j1_x, 12'h7F7);
    mouse(0, 8'h1E, 0, 8'h00, 2'b00, 1); step();
    mouse(0, 8'h1E, 0, 8'h00, 2'b00, 0); step();
    check("pre_rst_x", bus.j1_x, 12'h757);
    mouse(0, 8'h1E, 0, 8'h00, 2'b00, 1); step();
    #2 rst = 1;
    #1;
    check("arst_j1_x", bus.j1_x, 12'h7F7);
    check("arst_j2_x", bus.j2_x, 12'h7F7);
    check("arst_active", bus.mouse_active, 1'b0);
    model_reset();
    @(negedge clk) rst = 0;
    for (int n = 0; n < 500; n++) begin
      mouse(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 2'($urandom), ($urandom % 3) == 0);
      bus.mouse_en = ($urandom % 16) != 0;
      bus.joy1 = ($urandom % 12) == 0 ? 16'($urandom) : 16'h0;
      bus.recenter = ($urandom % 20) == 0;
      if (($urandom % 8) == 0) bus.swap = ~bus.swap;
      bus.joy2 = 16'($urandom);
      bus.joy1_x = 8'($urandom); bus.joy1_y = 8'($urandom);
      bus.joy2_x = 8'($urandom); bus.joy2_y = 8'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/analog_axis_mux.md
Name: analog_axis_mux

Overview:
- Builds the analog joystick inputs for the BBC Micro core: two 12-bit X/Y channels plus an active-low fire line per port.
- Sources are the HPS analog joysticks, or a PS/2 mouse emulating joystick A with integrated, clamped and saturated position.
- Sits between hps_io (joystick/mouse outputs) and the core's joystick1_*/joystick2_* ports.
- Also handles port swapping and the ADC offset-binary conversion.

Parameters:
- DELTA_MAX, 10: per-packet mouse delta clamp magnitude, in accumulator units.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_mouse  in  25  hps_io mouse: [24] strobe toggle, [4]/[5] X/Y sign, [15:8] X byte, [23:16] Y byte, [1:0] buttons
- mouse_en  in  1  1 = mouse may drive joystick A
- swap  in  1  1 = exchange port 1 and port 2
- recenter  in  1  core reset request; forces joystick mode and zeroes the accumulators
- joy1  in  16  digital joystick A; bit 4 = fire
- joy2  in  16  digital joystick B; bit 4 = fire
- joy1_x, joy1_y  in  8  signed analog joystick A
- joy2_x, joy2_y  in  8  signed analog joystick B
- j1_x, j1_y  out  12  port 1 ADC values
- j1_fire_n  out  1  port 1 fire, active low
- j2_x, j2_y  out  12  port 2 ADC values
- j2_fire_n  out  1  port 2 fire, active low
- mouse_active  out  1  1 when in MOUSE mode

Behaviour:
- Mode register, states JOY and MOUSE. Reset state is JOY.
- Strobe detect:
  - Register old_stb <= ps2_mouse[24] every cycle; reset value 0.
  - stroke = (old_stb != ps2_mouse[24]) & mouse_en.
- Delta per axis:
  - d9 = signed {sign, byte}.
  - d = arithmetic shift right of d9 by 1, giving the range -128..127.
  - dc = clamp(d, -DELTA_MAX, +DELTA_MAX).
- Accumulators ax, ay: signed 9-bit internally, held in the range -128..127, reset value 0.
- On stroke:
  - Mode becomes MOUSE.
  - ax <= sat(ax + dcx); ay <= sat(ay - dcy).
  - Saturation limits are -128 and +127.
- Exit condition: (joy1 != 0) | recenter | ~mouse_en.
  - Mode becomes JOY; ax, ay <= 0.
  - Takes priority over a stroke in the same cycle.
  - The stroke is dropped, but old_stb still updates.
- Source A, selected by mode:
  - MOUSE: value (ax, ay), fire = |ps2_mouse[1:0].
  - JOY: value (joy1_x, joy1_y), fire = joy1[4].
- Source B: always value (joy2_x, joy2_y), fire = joy2[4].
- Conversion of a signed 8-bit v:
  - u = 8'hFF - {~v[7], v[6:0]}.
  - ADC12 = {u, u[7:4]}.
  - v=0 gives 12'h7F7; v=+127 gives 12'h000; v=-128 gives 12'hFFF.
- Routing:
  - swap=0: port1 = A, port2 = B.
  - swap=1: port1 = B, port2 = A.
  - fire_n = ~fire.
- Latency:
  - All outputs are registered.
  - An input change appears 1 clock later.
  - A stroke affects the outputs 2 clocks after the strobe toggle: the accumulator updates, then the output register.
- Reset values:
  - j*_x, j*_y = 12'h7F7.
  - j*_fire_n = 1.
  - mouse_active = 0.
- Reset is asynchronous and may assert mid-stroke. Mode, accumulators, old_stb and outputs all return to their reset values immediately.
- mouse_active = (mode == MOUSE), registered along with the other outputs.

Decomposition:
- Shared package analog_axis_pkg:
  - enum axis_mode_t {JOY, MOUSE}
  - localparam ADC_CENTER = 12'h7F7
  - function to_adc12(signed [7:0]) returning [11:0]
  - function sat8(signed [9:0]) returning signed [8:0]
- One sub-module mouse_axis_accum, instantiated twice:
  - Inputs: sign, byte, stroke, clear, negate.
  - Output: signed accumulator.
  - Contains the shift, clamp and saturate logic.

Test Plan:
- Reset release with all inputs 0: all j*_x/j*_y = 12'h7F7, fire_n = 1, mouse_active = 0.
- mouse_en=1, X sign 0, X byte 0x1E, Y = 0, toggle strobe:
  - d=15, clamped to 10, so ax=10.
  - Two clocks later j1_x = 12'h757, j1_y = 12'h7F7, mouse_active = 1.
- Thirteen strokes of X byte 0x7F:
  - ax saturates at 127, so j1_x = 12'h000.
  - Then X sign 1, byte 0xE0 (d=-16, clamped to -10): ax = 117.
- Y sign 0, byte 0x08 from zero: ay = -4, so j1_y = 12'h838.
- Swap, fire and exit:
  - Set swap=1 with the mouse button held: j2_x carries the mouse value and j2_fire_n = 0.
  - Then joy1 = 16'h0010: the next cycle gives mode JOY, accumulators 0, j2_fire_n = 0 from joy1[4].
- Stroke in the same cycle as recenter=1:
  - The accumulator stays 0 and mode stays JOY.
  - Async reset asserted mid-stroke clears the outputs to 12'h7F7 without waiting for a clock edge.
